// File: rtl/jts16_obj_pkg.sv
// Shared definitions for the sprite table scanner.
//   state_t      : scanner FSM states
//   WORD_*       : word offsets inside an 8-word table entry
//   END_MARK     : bottom value that terminates the object list
//   word_addr()  : builds a table RAM word address from entry and word offset
package jts16_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_CHK,
        ST_RDW,
        ST_WAITDR,
        ST_DONE
    } state_t;

    localparam logic [2:0] WORD_TOP   = 3'd0;
    localparam logic [2:0] WORD_XPOS  = 3'd1;
    localparam logic [2:0] WORD_PITCH = 3'd2;
    localparam logic [2:0] WORD_ADDR  = 3'd3;
    localparam logic [2:0] WORD_ATTR  = 3'd4;

    localparam logic [7:0] END_MARK = 8'hFF;

    function automatic logic [9:0] word_addr(input logic [6:0] entry, input logic [2:0] word);
        return {entry, word};
    endfunction

endpackage

// File: rtl/jts16_obj_match.sv
// Combinational line test for one table entry.
//   word0    in  entry word 0: bottom in [15:8], top in [7:0]
//   line     in  line being prepared
//   visible  out top <= line < bottom (an empty entry is never visible)
//   end_mark out bottom is the end-of-list marker
//   row      out line - top, the row inside the object
module jts16_obj_match
    import jts16_obj_pkg::*;
(
    input  logic [15:0] word0,
    input  logic [7:0]  line,
    output logic        visible,
    output logic        end_mark,
    output logic [7:0]  row
);

    logic [7:0] top;
    logic [7:0] bottom;

    assign top      = word0[7:0];
    assign bottom   = word0[15:8];
    assign end_mark = (bottom == END_MARK);
    assign visible  = (line >= top) && (line < bottom);
    assign row      = line - top;

endmodule

// File: rtl/jts16_obj_scan.sv
// Object table scanner: walks the 8-word entries of the object table for the
// line given on hstart and hands every visible object to the draw engine.
//   clk, rst        clock, asynchronous active-low reset
//   hstart, vrender start pulse and line number
//   dump_en         debug dump owns the RAM port; scanner freezes
//   tbl_addr/dout   object table RAM port (1-cycle read latency)
//   dr_start, dr_*  draw request pulse and its fields; dr_busy back-pressure
//   scan_done       end-of-scan pulse; obj_cnt / ovf report that scan
module jts16_obj_scan
    import jts16_obj_pkg::*;
#(
    parameter int MAXOBJ  = 32,
    parameter int ENTRIES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hstart,
    input  logic [7:0]  vrender,
    input  logic        dump_en,
    output logic [9:0]  tbl_addr,
    input  logic [15:0] tbl_dout,
    output logic        dr_start,
    input  logic        dr_busy,
    output logic [8:0]  dr_xpos,
    output logic [15:0] dr_pitch,
    output logic [15:0] dr_addr,
    output logic [15:0] dr_attr,
    output logic [7:0]  dr_line,
    output logic        scan_done,
    output logic [7:0]  obj_cnt,
    output logic        ovf
);

    localparam logic [6:0] LAST_ENTRY = 7'(ENTRIES - 1);
    localparam logic [7:0] MAX_CNT    = 8'(MAXOBJ);

    state_t     state;
    logic [6:0] entry;
    logic [7:0] line;
    logic [7:0] count;
    logic       ovf_hit;
    logic [1:0] rdw_cnt;
    logic [9:0] addr_q;     // address presented this cycle
    logic [9:0] prev_addr;  // address whose data is on tbl_dout this cycle
    logic       frz;        // set while frozen; first clear cycle replays a read

    logic       visible;
    logic       end_mark;
    logic [7:0] row;

    jts16_obj_match u_match (
        .word0    (tbl_dout),
        .line     (line),
        .visible  (visible),
        .end_mark (end_mark),
        .row      (row)
    );

    // The dump port drove the RAM during the freeze, so the data expected on
    // the first live cycle is gone. Re-present the address whose data the
    // frozen state was about to consume, stall one cycle, then resume.
    assign tbl_addr = frz ? prev_addr : addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            entry     <= '0;
            line      <= '0;
            count     <= '0;
            ovf_hit   <= 1'b0;
            rdw_cnt   <= '0;
            addr_q    <= '0;
            prev_addr <= '0;
            frz       <= 1'b0;
            dr_start  <= 1'b0;
            dr_xpos   <= '0;
            dr_pitch  <= '0;
            dr_addr   <= '0;
            dr_attr   <= '0;
            dr_line   <= '0;
            scan_done <= 1'b0;
            obj_cnt   <= '0;
            ovf       <= 1'b0;
        end else begin
            dr_start  <= 1'b0;
            scan_done <= 1'b0;
            if (dump_en) begin
                frz <= 1'b1;
            end else if (hstart) begin
                // A scan finishing this very cycle still reports its result.
                if (state == ST_DONE) begin
                    scan_done <= 1'b1;
                    obj_cnt   <= count;
                    ovf       <= ovf_hit;
                end
                line    <= vrender;
                entry   <= '0;
                count   <= '0;
                ovf_hit <= 1'b0;
                frz     <= 1'b0;
                addr_q  <= word_addr(7'd0, WORD_TOP);
                state   <= ST_RD0;
            end else if (frz) begin
                frz <= 1'b0;
            end else begin
                prev_addr <= addr_q;
                case (state)
                    ST_IDLE: ;
                    ST_RD0: begin
                        // Word 1 goes out speculatively while word 0 is checked.
                        addr_q <= word_addr(entry, WORD_XPOS);
                        state  <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (end_mark) begin
                            state <= ST_DONE;
                        end else if (visible) begin
                            dr_line <= row;
                            addr_q  <= word_addr(entry, WORD_PITCH);
                            rdw_cnt <= '0;
                            state   <= ST_RDW;
                        end else if (entry == LAST_ENTRY) begin
                            state <= ST_DONE;
                        end else begin
                            entry  <= entry + 7'd1;
                            addr_q <= word_addr(entry + 7'd1, WORD_TOP);
                            state  <= ST_RD0;
                        end
                    end
                    ST_RDW: begin
                        rdw_cnt <= rdw_cnt + 2'd1;
                        case (rdw_cnt)
                            2'd0: begin
                                dr_xpos <= tbl_dout[8:0];
                                addr_q  <= word_addr(entry, WORD_ADDR);
                            end
                            2'd1: begin
                                dr_pitch <= tbl_dout;
                                addr_q   <= word_addr(entry, WORD_ATTR);
                            end
                            2'd2: dr_addr <= tbl_dout;
                            default: begin
                                dr_attr <= tbl_dout;
                                state   <= ST_WAITDR;
                            end
                        endcase
                    end
                    ST_WAITDR: begin
                        if (!dr_busy) begin
                            dr_start <= 1'b1;
                            count    <= count + 8'd1;
                            if (count + 8'd1 == MAX_CNT) begin
                                ovf_hit <= 1'b1;
                                state   <= ST_DONE;
                            end else if (entry == LAST_ENTRY) begin
                                state <= ST_DONE;
                            end else begin
                                entry  <= entry + 7'd1;
                                addr_q <= word_addr(entry + 7'd1, WORD_TOP);
                                state  <= ST_RD0;
                            end
                        end
                    end
                    ST_DONE: begin
                        scan_done <= 1'b1;
                        obj_cnt   <= count;
                        ovf       <= ovf_hit;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
